// File: rtl/axi_router_1xn_pkg.sv
// Shared types and helpers for the 1-to-N AXI address router.
package axi_router_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_ERRB} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR}  r_state_t;

   // Region hit test on addresses zero-extended to 64 bits: every bit at or
   // above 'bits' must match the base. A region of 2^64 or more always hits.
   function automatic logic addr_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [31:0] bits);
      logic [63:0] diff;
      diff = addr ^ base;
      if (bits >= 32'd64) return 1'b1;
      return (diff >> bits) == 64'd0;
   endfunction

endpackage

// File: rtl/axi_router_1xn_if.sv
// Upstream AXI slave bus plus NUM_M packed downstream AXI master buses.
// 'slave' is the router's view; 'master' is the view of the surrounding system.
interface axi_router_1xn_if #(
   parameter int NUM_M      = 2,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_W = DATA_WIDTH / 8;

   logic                          s_axi_awvalid, s_axi_awready;
   logic [ADDR_WIDTH-1:0]         s_axi_awaddr;
   logic [7:0]                    s_axi_awlen;
   logic                          s_axi_wvalid, s_axi_wready, s_axi_wlast;
   logic [DATA_WIDTH-1:0]         s_axi_wdata;
   logic [STRB_W-1:0]             s_axi_wstrb;
   logic                          s_axi_bvalid, s_axi_bready;
   logic [1:0]                    s_axi_bresp;
   logic                          s_axi_arvalid, s_axi_arready;
   logic [ADDR_WIDTH-1:0]         s_axi_araddr;
   logic [7:0]                    s_axi_arlen;
   logic                          s_axi_rvalid, s_axi_rready, s_axi_rlast;
   logic [DATA_WIDTH-1:0]         s_axi_rdata;
   logic [1:0]                    s_axi_rresp;

   logic [NUM_M-1:0]              m_axi_awvalid, m_axi_awready;
   logic [NUM_M*ADDR_WIDTH-1:0]   m_axi_awaddr;
   logic [NUM_M*8-1:0]            m_axi_awlen;
   logic [NUM_M-1:0]              m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [NUM_M*DATA_WIDTH-1:0]   m_axi_wdata;
   logic [NUM_M*STRB_W-1:0]       m_axi_wstrb;
   logic [NUM_M-1:0]              m_axi_bvalid, m_axi_bready;
   logic [NUM_M*2-1:0]            m_axi_bresp;
   logic [NUM_M-1:0]              m_axi_arvalid, m_axi_arready;
   logic [NUM_M*ADDR_WIDTH-1:0]   m_axi_araddr;
   logic [NUM_M*8-1:0]            m_axi_arlen;
   logic [NUM_M-1:0]              m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [NUM_M*DATA_WIDTH-1:0]   m_axi_rdata;
   logic [NUM_M*2-1:0]            m_axi_rresp;

   modport slave (
      input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
      input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      input  s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
      output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
      output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
      output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
      output m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
      input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
      input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
   );

   modport master (
      output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
      output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      output s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
      input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
      input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
      input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
      input  m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
      output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
      output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
   );
endinterface

// File: rtl/axi_router_1xn_decode.sv
// Address decoder: one comparator per port, lowest matching index wins.
module axi_router_decode
   import axi_router_pkg::*;
#(
   parameter int                          NUM_M       = 2,
   parameter int                          ADDR_WIDTH  = 64,
   parameter int                          SEL_W       = 1,
   parameter logic [NUM_M*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
   parameter logic [NUM_M*32-1:0]         M_ADDR_BITS = '0
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [SEL_W-1:0]      o_sel,
   output logic                  o_err
);

   // Scan from the top so the lowest hitting index is the one left standing.
   always_comb begin
      o_sel = '0;
      o_err = 1'b1;
      for (int i = NUM_M - 1; i >= 0; i--) begin
         if (addr_hit(64'(i_addr), 64'(M_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]),
                      M_ADDR_BITS[i*32 +: 32])) begin
            o_sel = SEL_W'(i);
            o_err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi_router_1xn.sv
// 1-to-N AXI4 address router. Read and write paths each hold one transaction
// in flight and run independently; unmapped accesses are answered locally
// with DECERR and counted.
//
//  state  | meaning
//  W_IDLE | accepting AW
//  W_XFER | AW to port and/or W beats in flight (or sinking W on DECERR)
//  W_RESP | B passed through from the selected port
//  W_ERRB | local DECERR write response
//  R_IDLE | accepting AR
//  R_ADDR | AR presented to the selected port
//  R_DATA | R passed through from the selected port
//  R_ERR  | local DECERR beats, arlen+1 of them
module axi_router_1xn
   import axi_router_pkg::*;
#(
   parameter int                          NUM_M       = 2,
   parameter int                          ADDR_WIDTH  = 64,
   parameter int                          DATA_WIDTH  = 32,
   // Slice 0 (least significant) belongs to port 0.
   parameter logic [NUM_M*ADDR_WIDTH-1:0] M_BASE_ADDR = {64'h4000_0000, 64'h0},
   parameter logic [NUM_M*32-1:0]         M_ADDR_BITS = {32'd30, 32'd30}
) (
   input  logic                  ap_clk,
   input  logic                  areset,
   axi_router_1xn_if.slave       bus,
   output logic [31:0]           decerr_count,
   input  logic                  decerr_clear,
   output logic                  busy
);

   localparam int SEL_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   w_state_t              r_wr_state, w_wr_next;
   r_state_t              r_rd_state, w_rd_next;
   logic                  r_live;
   logic [ADDR_WIDTH-1:0] r_aw_addr, r_ar_addr;
   logic [7:0]            r_aw_len, r_ar_len, r_beat;
   logic [SEL_W-1:0]      r_wr_sel, r_rd_sel, w_aw_sel, w_ar_sel;
   logic                  r_wr_err, w_aw_err, w_ar_err;
   logic                  r_aw_done, r_w_done, w_aw_hs, w_wlast_hs, w_wready;
   logic                  w_wr_inc, w_rd_inc;
   logic [31:0]           r_decerr_count;
   logic [32:0]           w_cnt_sum;

   axi_router_decode #(.NUM_M(NUM_M), .ADDR_WIDTH(ADDR_WIDTH), .SEL_W(SEL_W),
                       .M_BASE_ADDR(M_BASE_ADDR), .M_ADDR_BITS(M_ADDR_BITS))
      u_dec_aw (.i_addr(bus.s_axi_awaddr), .o_sel(w_aw_sel), .o_err(w_aw_err));

   axi_router_decode #(.NUM_M(NUM_M), .ADDR_WIDTH(ADDR_WIDTH), .SEL_W(SEL_W),
                       .M_BASE_ADDR(M_BASE_ADDR), .M_ADDR_BITS(M_ADDR_BITS))
      u_dec_ar (.i_addr(bus.s_axi_araddr), .o_sel(w_ar_sel), .o_err(w_ar_err));

   // Payloads fan out to every port; only the selected valid qualifies them.
   assign bus.m_axi_awaddr = {NUM_M{r_aw_addr}};
   assign bus.m_axi_awlen  = {NUM_M{r_aw_len}};
   assign bus.m_axi_wdata  = {NUM_M{bus.s_axi_wdata}};
   assign bus.m_axi_wstrb  = {NUM_M{bus.s_axi_wstrb}};
   assign bus.m_axi_wlast  = {NUM_M{bus.s_axi_wlast}};
   assign bus.m_axi_araddr = {NUM_M{r_ar_addr}};
   assign bus.m_axi_arlen  = {NUM_M{r_ar_len}};

   assign busy         = (r_wr_state != W_IDLE) || (r_rd_state != R_IDLE);
   assign decerr_count = r_decerr_count;

   // Holds slave readies low for the first cycle after reset release.
   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) r_live <= 1'b0;
      else        r_live <= 1'b1;
   end

   // FSM state registers.
   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
      end else begin
         r_wr_state <= w_wr_next;
         r_rd_state <= w_rd_next;
      end
   end

   // Write-side capture and AW/W completion tracking.
   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         r_aw_addr <= '0;
         r_aw_len  <= '0;
         r_wr_sel  <= '0;
         r_wr_err  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (r_wr_state == W_IDLE) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         if (bus.s_axi_awready && bus.s_axi_awvalid) begin
            r_aw_addr <= bus.s_axi_awaddr;
            r_aw_len  <= bus.s_axi_awlen;
            r_wr_sel  <= w_aw_sel;
            r_wr_err  <= w_aw_err;
         end
      end else begin
         if (w_aw_hs)    r_aw_done <= 1'b1;
         if (w_wlast_hs) r_w_done  <= 1'b1;
      end
   end

   // Write next-state and handshake steering.
   always_comb begin
      w_wr_next          = r_wr_state;
      w_wr_inc           = 1'b0;
      w_aw_hs            = 1'b0;
      w_wlast_hs         = 1'b0;
      w_wready           = 1'b0;
      bus.s_axi_awready  = 1'b0;
      bus.s_axi_bvalid   = 1'b0;
      bus.s_axi_bresp    = RESP_OKAY;
      bus.m_axi_awvalid  = '0;
      bus.m_axi_wvalid   = '0;
      bus.m_axi_bready   = '0;
      case (r_wr_state)
         W_IDLE: begin
            bus.s_axi_awready = r_live;
            if (r_live && bus.s_axi_awvalid) w_wr_next = W_XFER;
         end
         W_XFER: begin
            if (r_wr_err) begin
               w_wready = 1'b1;
               if (bus.s_axi_wvalid && bus.s_axi_wlast) w_wr_next = W_ERRB;
            end else begin
               bus.m_axi_awvalid[r_wr_sel] = !r_aw_done;
               bus.m_axi_wvalid[r_wr_sel]  = bus.s_axi_wvalid && !r_w_done;
               w_wready   = bus.m_axi_wready[r_wr_sel] && !r_w_done;
               w_aw_hs    = !r_aw_done && bus.m_axi_awready[r_wr_sel];
               w_wlast_hs = bus.s_axi_wvalid && w_wready && bus.s_axi_wlast;
               if ((r_aw_done || w_aw_hs) && (r_w_done || w_wlast_hs)) w_wr_next = W_RESP;
            end
         end
         W_RESP: begin
            bus.s_axi_bvalid           = bus.m_axi_bvalid[r_wr_sel];
            bus.s_axi_bresp            = bus.m_axi_bresp[int'(r_wr_sel)*2 +: 2];
            bus.m_axi_bready[r_wr_sel] = bus.s_axi_bready;
            if (bus.m_axi_bvalid[r_wr_sel] && bus.s_axi_bready) w_wr_next = W_IDLE;
         end
         W_ERRB: begin
            bus.s_axi_bvalid = 1'b1;
            bus.s_axi_bresp  = RESP_DECERR;
            if (bus.s_axi_bready) begin
               w_wr_next = W_IDLE;
               w_wr_inc  = 1'b1;
            end
         end
         default: w_wr_next = W_IDLE;
      endcase
   end

   assign bus.s_axi_wready = w_wready;

   // Read-side capture and local DECERR beat counter.
   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         r_ar_addr <= '0;
         r_ar_len  <= '0;
         r_rd_sel  <= '0;
         r_beat    <= '0;
      end else if (r_rd_state == R_IDLE) begin
         r_beat <= '0;
         if (bus.s_axi_arready && bus.s_axi_arvalid) begin
            r_ar_addr <= bus.s_axi_araddr;
            r_ar_len  <= bus.s_axi_arlen;
            r_rd_sel  <= w_ar_sel;
         end
      end else if (r_rd_state == R_ERR && bus.s_axi_rready && r_beat != r_ar_len) begin
         r_beat <= r_beat + 8'd1;
      end
   end

   // Read next-state and handshake steering.
   always_comb begin
      w_rd_next          = r_rd_state;
      w_rd_inc           = 1'b0;
      bus.s_axi_arready  = 1'b0;
      bus.s_axi_rvalid   = 1'b0;
      bus.s_axi_rdata    = '0;
      bus.s_axi_rresp    = RESP_OKAY;
      bus.s_axi_rlast    = 1'b0;
      bus.m_axi_arvalid  = '0;
      bus.m_axi_rready   = '0;
      case (r_rd_state)
         R_IDLE: begin
            bus.s_axi_arready = r_live;
            if (r_live && bus.s_axi_arvalid) w_rd_next = w_ar_err ? R_ERR : R_ADDR;
         end
         R_ADDR: begin
            bus.m_axi_arvalid[r_rd_sel] = 1'b1;
            if (bus.m_axi_arready[r_rd_sel]) w_rd_next = R_DATA;
         end
         R_DATA: begin
            bus.s_axi_rvalid           = bus.m_axi_rvalid[r_rd_sel];
            bus.s_axi_rdata            = bus.m_axi_rdata[int'(r_rd_sel)*DATA_WIDTH +: DATA_WIDTH];
            bus.s_axi_rresp            = bus.m_axi_rresp[int'(r_rd_sel)*2 +: 2];
            bus.s_axi_rlast            = bus.m_axi_rlast[r_rd_sel];
            bus.m_axi_rready[r_rd_sel] = bus.s_axi_rready;
            if (bus.m_axi_rvalid[r_rd_sel] && bus.s_axi_rready && bus.m_axi_rlast[r_rd_sel])
               w_rd_next = R_IDLE;
         end
         R_ERR: begin
            bus.s_axi_rvalid = 1'b1;
            bus.s_axi_rresp  = RESP_DECERR;
            bus.s_axi_rlast  = (r_beat == r_ar_len);
            if (bus.s_axi_rready && r_beat == r_ar_len) begin
               w_rd_next = R_IDLE;
               w_rd_inc  = 1'b1;
            end
         end
         default: w_rd_next = R_IDLE;
      endcase
   end

   assign w_cnt_sum = {1'b0, r_decerr_count} + {32'd0, w_wr_inc} + {32'd0, w_rd_inc};

   // Saturating DECERR counter; clear beats a same-cycle increment.
   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset)                   r_decerr_count <= '0;
      else if (decerr_clear)        r_decerr_count <= '0;
      else if (w_wr_inc || w_rd_inc) r_decerr_count <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
   end

endmodule
